i2c_target_rx: RTL

- I2C target (responder) engine: the other end of the bus whose SCL our controller generates.
- Samples SCL/SDA in the 156.25 MHz fabric domain, detects START/STOP, matches a 7-bit address and ACKs it.
- Receives write bytes and serves read bytes.
- Drives SDA only through an open-drain tristate enable. Used for loopback test of the controller and as an on-FPGA I2C endpoint.

---
 rtl/i2c_target_rx.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/i2c_target_rx.sv
// I2C target engine: synchronises SCL/SDA, decodes START/STOP, ACKs address ADDR,
// receives write bytes and serves read bytes through an open-drain SDA enable.
module i2c_target_rx #(
   parameter logic [6:0] ADDR = 7'h50
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       sda_t,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   input  logic [7:0] tx_data,
   output logic       tx_req,
   output logic       rw,
   output logic       busy
);

   typedef enum logic [2:0] {
      ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_WR_DATA, ST_WR_ACK, ST_RD_DATA, ST_RD_ACK, ST_WAIT_STOP
   } state_t;

   state_t state, state_nxt;

   logic [1:0] scl_sync, sda_sync;
   logic       scl_hist, sda_hist;
   logic       scl_s, sda_s;
   logic       scl_rise, scl_fall, sda_rise, sda_fall;
   logic       start_det, stop_det;

   logic [7:0] sr;
   logic [6:0] tx_sr;
   logic [2:0] bit_cnt;
   logic       done;
   logic       ack_n;
   logic       addr_hit;

   logic       sda_t_nxt;
   logic       sr_shift, rx_load, rw_load, tx_load, tx_shift, ack_cap, cnt_clr;

   // Preset to 1 so an idle (pulled-up) bus produces no edges when reset releases.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         scl_sync <= 2'b11;
         sda_sync <= 2'b11;
         scl_hist <= 1'b1;
         sda_hist <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments make each flop take its predecessor's old value, forming a real shift chain.
         scl_sync <= {scl_sync[0], scl_i};
         sda_sync <= {sda_sync[0], sda_i};
         scl_hist <= scl_sync[1];
         sda_hist <= sda_sync[1];
      end
   end

   assign scl_s     = scl_sync[1];
   assign sda_s     = sda_sync[1];
   assign scl_rise  = scl_s & ~scl_hist;
   assign scl_fall  = ~scl_s & scl_hist;
   assign sda_rise  = sda_s & ~sda_hist;
   assign sda_fall  = ~sda_s & sda_hist;
   assign start_det = sda_fall & scl_s;
   assign stop_det  = sda_rise & scl_s;
   assign addr_hit  = (sr[7:1] == ADDR);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      // NOTE: assigning a default before the case keeps every path covered, so no latch is inferred.
      state_nxt = state;
      if (start_det) begin
         state_nxt = ST_ADDR;
      end else if (stop_det) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_ADDR:     if (scl_fall && done) state_nxt = addr_hit ? ST_ADDR_ACK : ST_WAIT_STOP;
            ST_ADDR_ACK: if (scl_fall) state_nxt = rw ? ST_RD_DATA : ST_WR_DATA;
            ST_WR_DATA:  if (scl_fall && done) state_nxt = ST_WR_ACK;
            // sda_t still holds the ACK/NACK we drove during this ninth clock.
            ST_WR_ACK:   if (scl_fall) state_nxt = sda_t ? ST_WAIT_STOP : ST_WR_DATA;
            ST_RD_DATA:  if (scl_fall && bit_cnt == 3'd7) state_nxt = ST_RD_ACK;
            ST_RD_ACK:   if (scl_fall) state_nxt = ack_n ? ST_WAIT_STOP : ST_RD_DATA;
            default:     state_nxt = state;
         endcase
      end
   end

   always_comb begin
      sda_t_nxt = sda_t;
      sr_shift  = 1'b0;
      rx_load   = 1'b0;
      rw_load   = 1'b0;
      tx_load   = 1'b0;
      tx_shift  = 1'b0;
      ack_cap   = 1'b0;
      cnt_clr   = 1'b0;
      busy      = (state != ST_IDLE);
      if (start_det || stop_det) begin
         sda_t_nxt = 1'b1;
         cnt_clr   = 1'b1;
      end else begin
         case (state)
            ST_ADDR: begin
               if (scl_rise && !done) begin
                  sr_shift = 1'b1;
                  rw_load  = (bit_cnt == 3'd7);
               end
               if (scl_fall && done) begin
                  sda_t_nxt = ~addr_hit;
                  cnt_clr   = 1'b1;
               end
            end
            ST_ADDR_ACK: begin
               if (scl_fall) begin
                  sda_t_nxt = rw ? tx_data[7] : 1'b1;
                  tx_load   = rw;
                  cnt_clr   = 1'b1;
               end
            end
            ST_WR_DATA: begin
               if (scl_rise && !done) begin
                  sr_shift = 1'b1;
                  rx_load  = (bit_cnt == 3'd7);
               end
               if (scl_fall && done) begin
                  sda_t_nxt = ~rx_ready;
                  cnt_clr   = 1'b1;
               end
            end
            ST_WR_ACK: if (scl_fall) sda_t_nxt = 1'b1;
            ST_RD_DATA: begin
               if (scl_fall) begin
                  if (bit_cnt == 3'd7) begin
                     sda_t_nxt = 1'b1;
                     cnt_clr   = 1'b1;
                  end else begin
                     sda_t_nxt = tx_sr[6];
                     tx_shift  = 1'b1;
                  end
               end
            end
            ST_RD_ACK: begin
               ack_cap = scl_rise;
               if (scl_fall && !ack_n) begin
                  sda_t_nxt = tx_data[7];
                  tx_load   = 1'b1;
                  cnt_clr   = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sda_t    <= 1'b1;
         rx_data  <= 8'h00;
         rx_valid <= 1'b0;
         tx_req   <= 1'b0;
         rw       <= 1'b0;
         sr       <= 8'h00;
         tx_sr    <= 7'h00;
         bit_cnt  <= 3'd0;
         done     <= 1'b0;
         ack_n    <= 1'b1;
      end else begin
         sda_t    <= sda_t_nxt;
         rx_valid <= rx_load;
         tx_req   <= tx_load;
         if (sr_shift) sr <= {sr[6:0], sda_s};
         if (rx_load)  rx_data <= {sr[6:0], sda_s};
         if (rw_load)  rw <= sda_s;
         if (ack_cap)  ack_n <= sda_s;
         if (tx_load)       tx_sr <= tx_data[6:0];
         else if (tx_shift) tx_sr <= {tx_sr[5:0], 1'b0};
         // The counter wraps to 0 on the eighth bit; done marks the byte boundary.
         if (cnt_clr) begin
            bit_cnt <= 3'd0;
            done    <= 1'b0;
         end else if (sr_shift || tx_shift) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (sr_shift && bit_cnt == 3'd7) done <= 1'b1;
         end
      end
   end

endmodule
